// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the fetch PC, issues single-outstanding word
// requests to instruction memory, buffers responses in a small prefetch FIFO
// and hands {instr, pc} to decode over a valid/ready handshake.
module if_stage #(
  parameter logic [31:0] BOOT_ADDR  = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  output logic        instr_req_o,
  output logic [31:0] instr_addr_o,
  input  logic        instr_gnt_i,
  input  logic        instr_rvalid_i,
  input  logic [31:0] instr_rdata_i,
  input  logic [1:0]  pc_mux_i,
  input  logic        jal_op_i,
  input  logic [31:0] jump_target_i,
  input  logic [31:0] branch_target_i,
  input  logic        id_ready_i,
  output logic        instr_valid_id_o,
  output logic [31:0] instr_rdata_id_o,
  output logic [31:0] pc_id_o
);

  localparam int          PTR_W   = $clog2(FIFO_DEPTH);
  localparam int          CNT_W   = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
  localparam logic [31:0] NOP     = 32'h0000_0013;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_STALL} state_e;

  state_e            state_q;
  logic [31:0]       fetch_pc_q;
  logic              discard_q;

  logic [31:0]       data_q [FIFO_DEPTH];
  logic [31:0]       addr_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  rptr_q, wptr_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_after;

  logic              redirect;
  logic [31:0]       target_raw, target;
  logic              gnt_acc, push, pop;

  // Redirect decode; BOOT beats BRANCH beats a qualified JUMP.
  always_comb begin
    redirect   = 1'b0;
    target_raw = BOOT_ADDR;
    if (pc_mux_i == 2'b11) begin
      redirect   = 1'b1;
      target_raw = BOOT_ADDR;
    end else if (pc_mux_i == 2'b10) begin
      redirect   = 1'b1;
      target_raw = branch_target_i;
    end else if (pc_mux_i == 2'b01 && jal_op_i) begin
      redirect   = 1'b1;
      target_raw = jump_target_i;
    end
  end

  assign target = target_raw & 32'hFFFF_FFFC;

  // While a discarded response is still in flight the request is held low,
  // so memory never sees two outstanding transactions.
  assign instr_req_o  = (state_q == S_REQ) && !discard_q;
  assign instr_addr_o = fetch_pc_q;
  assign gnt_acc      = instr_req_o && instr_gnt_i;

  assign instr_valid_id_o = (cnt_q != '0);
  assign instr_rdata_id_o = data_q[rptr_q];
  assign pc_id_o          = addr_q[rptr_q];

  // A redirect drops both the head on offer and any response arriving with it.
  assign pop  = instr_valid_id_o && id_ready_i && !redirect;
  assign push = (state_q == S_WAIT) && instr_rvalid_i && !discard_q && !redirect;

  // FIFO occupancy next cycle, and occupancy seen by the WAIT exit decision.
  always_comb begin
    cnt_d = cnt_q;
    if (push && !pop)      cnt_d = cnt_q + CNT_W'(1);
    else if (!push && pop) cnt_d = cnt_q - CNT_W'(1);
    cnt_after = pop ? cnt_q : cnt_q + CNT_W'(1);
  end

  // Fetch FSM, fetch PC and discard tracking.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      fetch_pc_q <= BOOT_ADDR;
      discard_q  <= 1'b0;
    end else if (redirect) begin
      state_q    <= S_REQ;
      fetch_pc_q <= target;
      discard_q  <= gnt_acc || ((discard_q || state_q == S_WAIT) && !instr_rvalid_i);
    end else begin
      case (state_q)
        S_IDLE: state_q <= S_REQ;
        S_REQ: begin
          if (discard_q) begin
            if (instr_rvalid_i) discard_q <= 1'b0;
          end else if (gnt_acc) begin
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (instr_rvalid_i) begin
            fetch_pc_q <= fetch_pc_q + 32'd4;
            state_q    <= (cnt_after < DEPTH_C) ? S_REQ : S_STALL;
          end
        end
        S_STALL: if (pop) state_q <= S_REQ;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Prefetch FIFO storage and pointers; a redirect empties it in one cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        data_q[i] <= NOP;
        addr_q[i] <= '0;
      end
      rptr_q <= '0;
      wptr_q <= '0;
      cnt_q  <= '0;
    end else if (redirect) begin
      rptr_q <= '0;
      wptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push) begin
        data_q[wptr_q] <= instr_rdata_i;
        addr_q[wptr_q] <= fetch_pc_q;
        wptr_q         <= wptr_q + PTR_W'(1);
      end
      if (pop) rptr_q <= rptr_q + PTR_W'(1);
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: a one-cycle-latency memory model, an in-order
// PC tracker on the decode side, and hand-placed redirect/stall scenarios.
module tb_if_stage;

  localparam logic [31:0] KEY = 32'hC0DE_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req, gnt, rvalid;
  logic [31:0] addr, rdata;
  logic [1:0]  pc_mux;
  logic        jal;
  logic [31:0] jtgt, btgt;
  logic        id_ready;
  logic        vld;
  logic [31:0] rdata_id, pc_id;

  int          nchk = 0, nerr = 0;
  int          cyc = 0, first_gnt = -1, first_vld = -1, nacc = 0;
  logic        gnt_en;
  logic        pend = 1'b0;
  logic [31:0] pend_addr = '0;
  logic [31:0] exp_pc = '0;
  logic [31:0] a0;
  int          n0;

  always #5 clk = ~clk;

  if_stage #(.BOOT_ADDR(32'h0), .FIFO_DEPTH(2)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .instr_req_o(req), .instr_addr_o(addr), .instr_gnt_i(gnt),
    .instr_rvalid_i(rvalid), .instr_rdata_i(rdata),
    .pc_mux_i(pc_mux), .jal_op_i(jal), .jump_target_i(jtgt), .branch_target_i(btgt),
    .id_ready_i(id_ready), .instr_valid_id_o(vld),
    .instr_rdata_id_o(rdata_id), .pc_id_o(pc_id)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_req();
    int n = 0;
    while (!req && n < 30) begin step(1); n++; end
    chk("req_timeout", {31'b0, req}, 32'd1);
  endtask

  task automatic wait_vld();
    int n = 0;
    while (!vld && n < 30) begin step(1); n++; end
    chk("vld_timeout", {31'b0, vld}, 32'd1);
  endtask

  // Memory: grant when enabled, answer exactly one cycle after the grant.
  always @(negedge clk) begin
    rvalid = pend;
    rdata  = pend_addr ^ KEY;
    pend   = 1'b0;
    gnt    = req && gnt_en;
    if (gnt) begin
      pend      = 1'b1;
      pend_addr = addr;
    end
  end

  // Decode side: every accepted instruction must be the next expected PC.
  always @(negedge clk) begin
    #1;
    cyc++;
    if (rst_n) begin
      if (req && gnt && first_gnt < 0) first_gnt = cyc;
      if (vld && first_vld < 0) first_vld = cyc;
      if (vld && id_ready && !((pc_mux == 2'b01 && jal) || pc_mux[1])) begin
        chk("pc_seq", pc_id, exp_pc);
        chk("rdata", rdata_id, pc_id ^ KEY);
        exp_pc = exp_pc + 32'd4;
        nacc++;
      end
    end
  end

  initial begin
    rst_n = 1'b0; gnt_en = 1'b1; id_ready = 1'b1;
    pc_mux = 2'b00; jal = 1'b0; jtgt = '0; btgt = '0;
    step(2);
    chk("rst_req", {31'b0, req}, 32'd0);
    chk("rst_vld", {31'b0, vld}, 32'd0);
    chk("rst_rdata", rdata_id, 32'h0000_0013);
    chk("rst_pc", pc_id, 32'd0);
    chk("rst_addr", addr, 32'd0);
    exp_pc = 32'h0;
    rst_n = 1'b1;

    // Free-running fetch
    step(12);
    chk("latency", 32'(first_vld - first_gnt), 32'd2);
    chk("acc_run", {31'b0, nacc >= 4}, 32'd1);

    // Decode stalls: FIFO fills, requests stop, then drains in order
    id_ready = 1'b0;
    step(10);
    chk("full_req", {31'b0, req}, 32'd0);
    chk("full_vld", {31'b0, vld}, 32'd1);
    n0 = nacc;
    id_ready = 1'b1;
    step(6);
    chk("drain", {31'b0, (nacc - n0) >= 2}, 32'd1);

    // Grant withheld for 3 cycles: address held, data 2 cycles after grant
    wait_req();
    gnt_en = 1'b0;
    a0 = addr;
    for (int i = 0; i < 3; i++) begin
      step(1);
      chk("hold_req", {31'b0, req}, 32'd1);
      chk("hold_addr", addr, a0);
    end
    gnt_en = 1'b1;
    step(1);
    chk("gnt_lat1", {31'b0, vld}, 32'd0);
    step(1);
    chk("gnt_lat2", {31'b0, vld}, 32'd1);
    chk("gnt_pc", pc_id, a0);

    // Jump while the grant for the old PC is taken: old word discarded
    wait_req();
    pc_mux = 2'b01; jal = 1'b1; jtgt = 32'h100; exp_pc = 32'h100;
    step(1);
    pc_mux = 2'b00; jal = 1'b0;
    chk("jmp_flush", {31'b0, vld}, 32'd0);
    wait_vld();
    chk("jmp_pc", pc_id, 32'h100);
    chk("jmp_rdata", rdata_id, 32'h100 ^ KEY);

    // Unqualified jump (jal_op low) is ignored
    step(1);
    pc_mux = 2'b01; jal = 1'b0; jtgt = 32'h500;
    step(1);
    pc_mux = 2'b00;

    // Branch to misaligned target with jump in the same cycle, FIFO full
    id_ready = 1'b0;
    step(8);
    pc_mux = 2'b10; jal = 1'b1; jtgt = 32'h300; btgt = 32'h203; exp_pc = 32'h200;
    step(1);
    pc_mux = 2'b00; jal = 1'b0;
    chk("br_flush", {31'b0, vld}, 32'd0);
    chk("br_req", {31'b0, req}, 32'd1);
    chk("br_addr", addr, 32'h200);
    id_ready = 1'b1;
    wait_vld();
    chk("br_pc", pc_id, 32'h200);

    // BOOT redirect in the same cycle as the response: data dropped
    wait_req();
    step(1);
    pc_mux = 2'b11; exp_pc = 32'h0;
    step(1);
    pc_mux = 2'b00;
    wait_vld();
    chk("boot_pc", pc_id, 32'h0);

    // PC wraps at the top of the address space
    step(1);
    pc_mux = 2'b01; jal = 1'b1; jtgt = 32'hFFFF_FFF8; exp_pc = 32'hFFFF_FFF8;
    step(1);
    pc_mux = 2'b00; jal = 1'b0;
    n0 = nacc;
    step(14);
    chk("wrap_acc", {31'b0, (nacc - n0) >= 3}, 32'd1);

    // Reset pulse while a response is outstanding; the response lands after it
    wait_req();
    step(1);
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    exp_pc = 32'h0;
    #1;
    chk("mid_vld", {31'b0, vld}, 32'd0);
    chk("mid_rdata", rdata_id, 32'h0000_0013);
    step(1);
    chk("mid_vld2", {31'b0, vld}, 32'd0);
    chk("mid_req", {31'b0, req}, 32'd1);
    chk("mid_addr", addr, 32'h0);
    wait_vld();
    chk("mid_pc", pc_id, 32'h0);
    step(4);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
